// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
interface nibble_serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Add/subtract sequencer: one shared 4-bit ripple slice, one nibble per clock,
// LSB nibble first, with valid/ready handshakes on operand and result sides.
module nibble_serial_adder_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    nibble_serial_adder_ctrl_if.slave   bus,
    output logic                        busy
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int unsigned SHW = KW + 2;
    localparam logic [WIDTH-1:0] NIB_MASK = WIDTH'(4'hF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, a_nxt;
    logic [WIDTH-1:0] b_r, b_nxt;
    logic [WIDTH-1:0] sum_r, sum_nxt;
    logic             carry, carry_nxt;
    logic             cout_r, cout_nxt;
    logic             ovf_r, ovf_nxt;
    logic [KW-1:0]    k, k_nxt;
    logic             out_valid_r, out_valid_nxt;
    logic             busy_r, busy_nxt;
    logic             in_ready_r, in_ready_nxt;

    logic [SHW-1:0]   sh;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       s;
    logic [4:0]       c;
    logic             last;

    // Shared 4-bit slice: selected nibble of each operand plus the carry flop.
    always_comb begin
        sh    = {k, 2'b00};
        a_nib = 4'(a_r >> sh);
        b_nib = 4'(b_r >> sh);
        c[0]  = carry;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a_nib[i] ^ b_nib[i] ^ c[i];
            c[i+1] = (a_nib[i] & b_nib[i]) | (c[i] & (a_nib[i] ^ b_nib[i]));
        end
        last = (k == KW'(NIB - 1));
    end

    // Next-state and datapath update; subtraction is a + ~b + ~cin.
    always_comb begin
        state_nxt = state;
        a_nxt     = a_r;
        b_nxt     = b_r;
        sum_nxt   = sum_r;
        carry_nxt = carry;
        cout_nxt  = cout_r;
        ovf_nxt   = ovf_r;
        k_nxt     = k;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    a_nxt     = bus.a;
                    b_nxt     = bus.sub ? ~bus.b : bus.b;
                    carry_nxt = bus.cin ^ bus.sub;
                    k_nxt     = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                sum_nxt   = (sum_r & ~(NIB_MASK << sh)) | (WIDTH'(s) << sh);
                carry_nxt = c[4];
                k_nxt     = k + KW'(1);
                if (last) begin
                    cout_nxt  = c[4];
                    ovf_nxt   = c[3] ^ c[4];
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        out_valid_nxt = (state_nxt == DONE);
        busy_nxt      = (state_nxt == RUN);
        in_ready_nxt  = (state_nxt == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            carry       <= 1'b0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            k           <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state       <= state_nxt;
            a_r         <= a_nxt;
            b_r         <= b_nxt;
            sum_r       <= sum_nxt;
            carry       <= carry_nxt;
            cout_r      <= cout_nxt;
            ovf_r       <= ovf_nxt;
            k           <= k_nxt;
            out_valid_r <= out_valid_nxt;
            busy_r      <= busy_nxt;
            in_ready_r  <= in_ready_nxt;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench: 16-bit and 4-bit instances; driver pushes expected
// results, per-instance monitors pop and compare on result handshakes.
module tb_nibble_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus16 ();
    nibble_serial_adder_ctrl_if #(.WIDTH(4))  bus4 ();
    logic busy16, busy4;

    nibble_serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16),
        .busy  (busy16)
    );

    nibble_serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4),
        .busy  (busy4)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_rise = -1;
    bit   chk_period = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    function automatic exp_t mk(input logic [15:0] s, input logic co, input logic ov);
        exp_t e;
        e.sum = s; e.cout = co; e.ovf = ov; e.acc = 0;
        return e;
    endfunction

    // Behavioural reference: full-width arithmetic, signed overflow from operand signs.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        logic [16:0] full;
        logic [15:0] mask, bb, aa;
        mask  = 16'((17'd1 << w) - 17'd1);
        aa    = a & mask;
        bb    = sub ? (~b & mask) : (b & mask);
        full  = 17'(aa) + 17'(bb) + 17'(cin ^ sub);
        e.sum  = full[15:0] & mask;
        e.cout = full[w];
        e.ovf  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
        e.acc  = 0;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit w4, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input exp_t e,
                        input bit keep, output int acc);
        int n;
        bit rdy;
        n = 0;
        if (w4) begin
            bus4.a = a[3:0]; bus4.b = b[3:0]; bus4.cin = cin; bus4.sub = sub; bus4.in_valid = 1'b1;
        end else begin
            bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub; bus16.in_valid = 1'b1;
        end
        rdy = w4 ? bus4.in_ready : bus16.in_ready;
        while (!rdy && n < 100) begin
            @(negedge clk);
            n++;
            rdy = w4 ? bus4.in_ready : bus16.in_ready;
        end
        if (!rdy) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
            acc = -1;
            if (w4) bus4.in_valid = 1'b0; else bus16.in_valid = 1'b0;
            return;
        end
        acc   = cyc + 1;
        e.acc = acc;
        if (w4) q4.push_back(e); else q16.push_back(e);
        @(negedge clk);
        if (!keep) begin
            if (w4) bus4.in_valid = 1'b0; else bus16.in_valid = 1'b0;
        end
    endtask

    // 16-bit result monitor: latency, period, spurious valid, and data checks.
    initial begin : mon16
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin prev = 1'b0; continue; end
            if (bus16.out_valid && !prev) begin
                if (q16.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious16 out_valid actual=1 required=0");
                end else begin
                    chk("latency16", 32'(cyc - q16[0].acc), 32'd4);
                    if (chk_period && last_rise >= 0) chk("period16", 32'(cyc - last_rise), 32'd6);
                    last_rise = cyc;
                end
            end
            if (bus16.out_valid && bus16.out_ready && q16.size() > 0) begin
                e = q16.pop_front();
                chk("sum16",  32'(bus16.sum),  32'(e.sum));
                chk("cout16", 32'(bus16.cout), 32'(e.cout));
                chk("ovf16",  32'(bus16.ovf),  32'(e.ovf));
            end
            prev = bus16.out_valid;
        end
    end

    initial begin : mon4
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin prev = 1'b0; continue; end
            if (bus4.out_valid && !prev) begin
                if (q4.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious4 out_valid actual=1 required=0");
                end else begin
                    chk("latency4", 32'(cyc - q4[0].acc), 32'd1);
                end
            end
            if (bus4.out_valid && bus4.out_ready && q4.size() > 0) begin
                e = q4.pop_front();
                chk("sum4",  32'(bus4.sum),  32'(e.sum));
                chk("cout4", 32'(bus4.cout), 32'(e.cout));
                chk("ovf4",  32'(bus4.ovf),  32'(e.ovf));
            end
            prev = bus4.out_valid;
        end
    end

    initial begin : stim
        int acc, acc2, exit_cyc, n;
        logic [15:0] ra, rb;
        logic rc, rs;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
        bus16.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.sub = 1'b0;
        bus4.out_ready = 1'b1;

        #12;
        chk("rst_out_valid", 32'(bus16.out_valid), 32'd0);
        chk("rst_sum",       32'(bus16.sum),       32'd0);
        chk("rst_busy",      32'(busy16),          32'd0);
        chk("rst_in_ready",  32'(bus16.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed add/sub vectors with hand-computed results.
        send(0, 16'h1234, 16'h4321, 1'b0, 1'b0, mk(16'h5555, 1'b0, 1'b0), 0, acc);
        send(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0), 0, acc);
        send(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1), 0, acc);
        send(0, 16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0), 0, acc);
        send(0, 16'h0010, 16'h0001, 1'b1, 1'b1, mk(16'h000E, 1'b1, 1'b0), 0, acc);
        send(0, 16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1), 0, acc);

        // Reset in the 2nd RUN cycle discards the operation.
        send(0, 16'h1111, 16'h1111, 1'b0, 1'b0, mk(16'h2222, 1'b0, 1'b0), 0, acc);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        q16.delete();
        chk("midrst_out_valid", 32'(bus16.out_valid), 32'd0);
        chk("midrst_busy",      32'(busy16),          32'd0);
        chk("midrst_sum",       32'(bus16.sum),       32'd0);
        chk("midrst_cout",      32'(bus16.cout),      32'd0);
        chk("midrst_ovf",       32'(bus16.ovf),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", 32'(bus16.in_ready), 32'd1);
        chk("postrst_busy",     32'(busy16),         32'd0);
        repeat (8) @(negedge clk);

        // Backpressure for 3 DONE cycles with the next request already pending.
        bus16.out_ready = 1'b0;
        send(0, 16'h1234, 16'h4321, 1'b0, 1'b0, mk(16'h5555, 1'b0, 1'b0), 1, acc);
        bus16.a = 16'h0005; bus16.b = 16'h0007; bus16.sub = 1'b1;
        n = 0;
        while (!bus16.out_valid && n < 20) begin @(negedge clk); n++; end
        if (!bus16.out_valid) begin
            total++; bad++;
            $display("FAIL bp_wait out_valid actual=0 required=1");
        end
        for (int i = 0; i < 3; i++) begin
            chk("bp_sum",      32'(bus16.sum),       32'h5555);
            chk("bp_cout",     32'(bus16.cout),      32'd0);
            chk("bp_ovf",      32'(bus16.ovf),       32'd0);
            chk("bp_in_ready", 32'(bus16.in_ready),  32'd0);
            chk("bp_valid",    32'(bus16.out_valid), 32'd1);
            @(negedge clk);
        end
        bus16.out_ready = 1'b1;
        exit_cyc = cyc + 1;
        send(0, 16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0), 0, acc2);
        chk("accept_after_idle", 32'(acc2), 32'(exit_cyc + 1));

        // Input changes during RUN must not disturb the captured operands.
        send(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1), 1, acc);
        for (int i = 0; i < 3; i++) begin
            bus16.a = 16'($urandom);
            bus16.b = 16'($urandom);
            bus16.sub = ~bus16.sub;
            bus16.cin = ~bus16.cin;
            bus16.in_valid = 1'(i % 2);
            @(negedge clk);
        end
        bus16.in_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Exhaustive 4-bit instance against the reference model.
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    for (int is = 0; is < 2; is++)
                        send(1, 16'(ia), 16'(ib), 1'(ic), 1'(is),
                             model(4, 16'(ia), 16'(ib), 1'(ic), 1'(is)), 1, acc);
        bus4.in_valid = 1'b0;

        // Back-to-back random stream on the 16-bit instance.
        repeat (4) @(negedge clk);
        chk_period = 1'b1;
        last_rise = -1;
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            send(0, ra, rb, rc, rs, model(16, ra, rb, rc, rs), 1, acc);
        end
        bus16.in_valid = 1'b0;

        n = 0;
        while ((q16.size() != 0 || q4.size() != 0) && n < 200) begin @(negedge clk); n++; end
        if (q16.size() != 0 || q4.size() != 0) begin
            total++; bad++;
            $display("FAIL drain pending actual=%0d required=0", q16.size() + q4.size());
        end
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds or subtracts two WIDTH-bit operands through a single shared 4-bit ripple-carry slice, one nibble per clock, LSB nibble first.
- The carry between nibbles is held in a flop.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area against a full-width ripple adder.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibble steps. Derived locally; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands. High only in IDLE.
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry-in for add; borrow-in for sub
- sub  input  1  0 = a+b+cin; 1 = a-b-cin
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out for add; for sub, 1 = no borrow (a >= b+cin)
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)
- busy  output  1  high in RUN

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n low forces state IDLE asynchronously.
  - Reset values: sum=0, cout=0, ovf=0, out_valid=0, busy=0, nibble index k=0, carry flop=0.
  - in_ready=1 once in IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture a into A_r, and capture b into B_r, inverted if sub=1.
  - Initial carry = cin when sub=0, ~cin when sub=1.
  - Clear k to 0; go to RUN.
- RUN:
  - busy=1, in_ready=0.
  - Each edge computes {c4, s[3:0]} = A_r[4k+3:4k] + B_r[4k+3:4k] + carry, bit-serial ripple inside the slice.
  - Writes s into sum[4k+3:4k], sets carry=c4, and increments k.
  - On the edge where k=NIB-1:
    - cout = c4 of that nibble;
    - ovf = c3 XOR c4 of that nibble (c3 is the carry into the MSB);
    - go to DONE.
- DONE:
  - out_valid=1.
  - sum, cout and ovf are held stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE, out_valid=0.
  - A new operand can be accepted no earlier than the next edge. There is no overlap of output and input acceptance.
- Latency: out_valid rises exactly NIB edges after the accepting edge (4 for WIDTH=16, 1 for WIDTH=4). Throughput is one operation per NIB+2 cycles with out_ready tied high.
- Input handling:
  - a, b, cin and sub are sampled only at the accepting edge.
  - Changes in RUN or DONE have no effect.
  - in_valid outside IDLE is ignored; the producer must hold its request until in_ready.
- sum during RUN holds partial results. It is valid only when out_valid=1.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Reset mid-RUN or mid-DONE aborts the operation: outputs go to reset values, and the pending result is discarded and never presented.
- out_ready in IDLE or RUN is ignored.

Test Plan:
- Reset: assert rst_n low during the 2nd RUN cycle -> out_valid, busy, sum, cout and ovf go to 0 immediately; state is IDLE; in_ready=1 after release; no spurious out_valid.
- Add (WIDTH=16): a=0x1234, b=0x4321, cin=0, sub=0 -> out_valid 4 edges after accept; sum=0x5555, cout=0, ovf=0. Also a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0; and a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Sub:
  - a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - a=0x0010, b=0x0001, cin=1 -> sum=0x000E, cout=1.
- Backpressure and isolation:
  - Hold out_ready=0 for 3 cycles in DONE -> sum, cout and ovf stable and in_ready=0.
  - Toggle a, b, sub and in_valid during RUN -> result unchanged.
  - With in_valid=1 throughout and out_ready=1 on the 4th cycle -> next operation accepted only in the cycle after return to IDLE.
- Exhaustive (WIDTH=4): all 1024 combinations of a, b, cin and sub -> sum, cout and ovf match a behavioural model; out_valid latency = 1 edge every time.
- Back-to-back stream (WIDTH=16, out_ready=1, in_valid=1): 100 random operand sets -> results match the model in order; period between out_valid pulses = 6 cycles.
